// File: rtl/memory_issue_unit_if.sv
// Memory-side request/response bundle between memory_issue_unit and memory_unit.
// Ports: load/store/address/store_data flow issue->memory; ready/valid/data_addr/load_data flow back.
// master = issue unit side, slave = memory_unit side.
interface memory_issue_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    load;
  logic                    store;
  logic [ADDRESS_BITS-1:0] address;
  logic [DATA_WIDTH-1:0]   store_data;
  logic                    ready;
  logic                    valid;
  logic [ADDRESS_BITS-1:0] data_addr;
  logic [DATA_WIDTH-1:0]   load_data;

  modport master (
    output load, store, address, store_data,
    input  ready, valid, data_addr, load_data
  );

  modport slave (
    input  load, store, address, store_data,
    output ready, valid, data_addr, load_data
  );
endinterface

// File: rtl/memory_issue_unit.sv
// One-entry load/store request slot in front of memory_unit plus an in-order outstanding-load tracker.
// Latency: capture -> memory request 1 cycle; load response valid -> wb_valid 1 cycle.
// Backpressure: issue_stall holds execute while the slot is blocked (ready=0) or the tracker is full.
// Ports: clock/reset; execute request (ex_*); hazard check (rs1/rs2 -> raw_hazard);
//        memory bus (mem, master modport); writeback (wb_*); status (pending_count, resp_error); report.
module memory_issue_unit #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int REG_BITS     = 5,
  parameter int DEPTH_BITS   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  // execute stage request
  input  logic                    ex_load,
  input  logic                    ex_store,
  input  logic [ADDRESS_BITS-1:0] ex_address,
  input  logic [DATA_WIDTH-1:0]   ex_store_data,
  input  logic [REG_BITS-1:0]     ex_rd,
  // decode-stage hazard check
  input  logic [REG_BITS-1:0]     rs1,
  input  logic [REG_BITS-1:0]     rs2,
  output logic                    issue_stall,
  output logic                    raw_hazard,
  // memory_unit side
  memory_issue_unit_if.master     mem,
  // writeback
  output logic                    wb_valid,
  output logic [REG_BITS-1:0]     wb_rd,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic [ADDRESS_BITS-1:0] wb_address,
  // status
  output logic [DEPTH_BITS:0]     pending_count,
  output logic                    resp_error,
  input  logic                    report
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

  // request slot
  logic                    slot_valid;
  logic                    slot_store;
  logic [ADDRESS_BITS-1:0] slot_address;
  logic [DATA_WIDTH-1:0]   slot_data;

  // outstanding-load tracker (circular, in issue order)
  logic [REG_BITS-1:0]     trk_rd   [DEPTH];
  logic [ADDRESS_BITS-1:0] trk_addr [DEPTH];
  logic [DEPTH-1:0]        trk_vld;
  logic [DEPTH_BITS-1:0]   head;
  logic [DEPTH_BITS-1:0]   tail;
  logic [DEPTH_BITS:0]     count;

  logic request;
  logic capture;
  logic push;
  logic pop;

  // report is a simulation monitor hook; this RTL has no print logic, so the pin and CORE are sunk here.
  logic unused_report;
  assign unused_report = report ^ CORE[0];

  assign request = ex_load | ex_store;

  // Full is judged on the registered count, so a pop in the same cycle does not lift the stall.
  assign issue_stall = request & ((slot_valid & ~mem.ready) | (ex_load & (count == FULL_COUNT)));
  assign capture     = request & ~issue_stall;
  // Load and store together behaves as a store: no tracker entry.
  assign push        = capture & ex_load & ~ex_store;
  assign pop         = mem.valid & (count != '0) & (mem.data_addr == trk_addr[head]);

  assign mem.load       = slot_valid & ~slot_store;
  assign mem.store      = slot_valid & slot_store;
  assign mem.address    = slot_address;
  assign mem.store_data = slot_data;
  assign pending_count  = count;

  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (trk_vld[i] && trk_rd[i] != '0 && (trk_rd[i] == rs1 || trk_rd[i] == rs2)) begin
        raw_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid   <= 1'b0;
      slot_store   <= 1'b0;
      slot_address <= '0;
      slot_data    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        trk_rd[i]   <= '0;
        trk_addr[i] <= '0;
      end
      trk_vld      <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_address   <= '0;
      resp_error   <= 1'b0;
    end else begin
      // A capture overwrites the slot even when it drains at the same edge (back-to-back issue).
      if (capture) begin
        slot_valid   <= 1'b1;
        slot_store   <= ex_store;
        slot_address <= ex_address;
        slot_data    <= ex_store_data;
      end else if (slot_valid && mem.ready) begin
        slot_valid <= 1'b0;
      end

      // push and pop never touch the same entry: that would need count of 0 or DEPTH.
      if (push) begin
        trk_rd[tail]   <= ex_rd;
        trk_addr[tail] <= ex_address;
        trk_vld[tail]  <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        trk_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      wb_valid <= pop;
      if (pop) begin
        wb_rd      <= trk_rd[head];
        wb_data    <= mem.load_data;
        wb_address <= mem.data_addr;
      end

      if (mem.valid && !pop) begin
        resp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_issue_unit.sv
// Directed bench for memory_issue_unit: hand-computed expectations checked one cycle at a time.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Ports: DUT instantiated with its memory-side interface driven directly by the bench.
module tb_memory_issue_unit;
  localparam int DW = 32;
  localparam int AB = 20;
  localparam int RB = 5;
  localparam int DB = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          ex_load, ex_store;
  logic [AB-1:0] ex_address;
  logic [DW-1:0] ex_store_data;
  logic [RB-1:0] ex_rd, rs1, rs2;
  logic          issue_stall, raw_hazard;
  logic          wb_valid;
  logic [RB-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AB-1:0] wb_address;
  logic [DB:0]   pending_count;
  logic          resp_error;
  logic          report;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  memory_issue_unit_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) mem_if ();

  memory_issue_unit #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .REG_BITS(RB), .DEPTH_BITS(DB)
  ) dut (
    .clock(clock), .reset(reset),
    .ex_load(ex_load), .ex_store(ex_store), .ex_address(ex_address),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .rs1(rs1), .rs2(rs2),
    .issue_stall(issue_stall), .raw_hazard(raw_hazard),
    .mem(mem_if.master),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_address(wb_address),
    .pending_count(pending_count), .resp_error(resp_error),
    .report(report)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; report = 1'b0;
    ex_load = 1'b0; ex_store = 1'b0; ex_address = '0; ex_store_data = '0; ex_rd = '0;
    rs1 = '0; rs2 = '0;
    mem_if.ready = 1'b1; mem_if.valid = 1'b0; mem_if.data_addr = '0; mem_if.load_data = '0;
    tick(); tick();

    // reset state
    check("rst_pending", pending_count, 0);
    check("rst_load", mem_if.load, 0);
    check("rst_store", mem_if.store, 0);
    check("rst_address", mem_if.address, 0);
    check("rst_store_data", mem_if.store_data, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_raw", raw_hazard, 0);
    reset = 1'b0;

    // single load rd=5 @0x40, response three cycles later
    ex_load = 1'b1; ex_rd = 5; ex_address = 20'h00040;
    #1 check("ld_stall", issue_stall, 0);
    tick();
    ex_load = 1'b0;
    check("ld_slot_load", mem_if.load, 1);
    check("ld_slot_addr", mem_if.address, 20'h00040);
    check("ld_pending1", pending_count, 1);
    tick();
    check("ld_slot_drained", mem_if.load, 0);
    tick();
    mem_if.valid = 1'b1; mem_if.data_addr = 20'h00040; mem_if.load_data = 32'hDEADBEEF;
    #1 check("ld_wb_not_yet", wb_valid, 0);
    tick();
    mem_if.valid = 1'b0;
    check("ld_wb_valid", wb_valid, 1);
    check("ld_wb_rd", wb_rd, 5);
    check("ld_wb_data", wb_data, 32'hDEADBEEF);
    check("ld_wb_address", wb_address, 20'h00040);
    check("ld_pending0", pending_count, 0);
    check("ld_no_error", resp_error, 0);
    tick();
    check("ld_wb_pulse", wb_valid, 0);

    // stores against a blocked slot
    mem_if.ready = 1'b0;
    ex_store = 1'b1; ex_address = 20'h00080; ex_store_data = 32'h11112222;
    tick();
    ex_address = 20'h00084; ex_store_data = 32'h33334444;
    #1;
    check("st_store", mem_if.store, 1);
    check("st_addr", mem_if.address, 20'h00080);
    check("st_data", mem_if.store_data, 32'h11112222);
    check("st_stall", issue_stall, 1);
    tick();
    check("st_hold_addr", mem_if.address, 20'h00080);
    check("st_hold_data", mem_if.store_data, 32'h11112222);
    check("st_still_stall", issue_stall, 1);
    mem_if.ready = 1'b1;
    #1 check("st_stall_release", issue_stall, 0);
    tick();
    ex_store = 1'b0;
    check("st_b2b_addr", mem_if.address, 20'h00084);
    check("st_b2b_data", mem_if.store_data, 32'h33334444);
    check("st_b2b_store", mem_if.store, 1);
    check("st_no_track", pending_count, 0);
    tick();
    check("st_drained", mem_if.store, 0);
    check("st_no_wb", wb_valid, 0);

    // fill the tracker with four loads
    for (int i = 0; i < 4; i++) begin
      ex_load = 1'b1; ex_rd = RB'(i + 1); ex_address = AB'(32'h100 + 4 * i);
      tick();
    end
    check("full_pending4", pending_count, 4);
    ex_rd = 8; ex_address = 20'h00500;
    #1 check("full_load_stall", issue_stall, 1);
    ex_load = 1'b0; ex_store = 1'b1; ex_address = 20'h00600;
    #1 check("full_store_ok", issue_stall, 0);
    tick();
    ex_store = 1'b0;
    check("full_store_issued", mem_if.store, 1);
    check("full_pending_kept", pending_count, 4);

    // hazards
    rs1 = 3;
    #1 check("raw_rs1", raw_hazard, 1);
    rs1 = 0; rs2 = 4;
    #1 check("raw_rs2", raw_hazard, 1);
    rs2 = 9;
    #1 check("raw_none", raw_hazard, 0);
    rs2 = 0;

    // unmatched response
    mem_if.valid = 1'b1; mem_if.data_addr = 20'h00200; mem_if.load_data = 32'h0BADF00D;
    tick();
    mem_if.valid = 1'b0;
    check("mis_error", resp_error, 1);
    check("mis_no_wb", wb_valid, 0);
    check("mis_no_pop", pending_count, 4);

    // pop while full does not release the stall
    ex_load = 1'b1; ex_rd = 8; ex_address = 20'h00500;
    mem_if.valid = 1'b1; mem_if.data_addr = 20'h00100; mem_if.load_data = 32'hAAAA0001;
    #1 check("pop_full_stall", issue_stall, 1);
    tick();
    check("pop1_wb_valid", wb_valid, 1);
    check("pop1_wb_rd", wb_rd, 1);
    check("pop1_wb_data", wb_data, 32'hAAAA0001);
    check("pop1_pending", pending_count, 3);

    // push and pop at the same edge
    ex_rd = 7; ex_address = 20'h00300;
    mem_if.data_addr = 20'h00104; mem_if.load_data = 32'hAAAA0002;
    #1 check("pushpop_stall", issue_stall, 0);
    tick();
    ex_load = 1'b0; mem_if.valid = 1'b0;
    check("pushpop_pending", pending_count, 3);
    check("pushpop_wb_rd", wb_rd, 2);
    check("pushpop_wb_addr", wb_address, 20'h00104);
    rs1 = 7;
    #1 check("raw_rd7", raw_hazard, 1);

    mem_if.valid = 1'b1; mem_if.data_addr = 20'h00108; mem_if.load_data = 32'hAAAA0003;
    tick();
    mem_if.valid = 1'b0;
    check("pop3_wb_rd", wb_rd, 3);
    check("pop3_pending", pending_count, 2);

    // reset with two loads outstanding
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_pending", pending_count, 0);
    check("mid_rst_error", resp_error, 0);
    check("mid_rst_raw", raw_hazard, 0);
    rs1 = 0;
    mem_if.valid = 1'b1; mem_if.data_addr = 20'h0010C; mem_if.load_data = 32'hAAAA0004;
    tick();
    mem_if.valid = 1'b0;
    check("post_rst_error", resp_error, 1);
    check("post_rst_no_wb", wb_valid, 0);
    check("post_rst_pending", pending_count, 0);

    // rd=0 load: tracked, no hazard, written back with rd 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ex_load = 1'b1; ex_rd = 0; ex_address = 20'h00400;
    tick();
    ex_load = 1'b0;
    check("rd0_pending", pending_count, 1);
    rs1 = 0; rs2 = 0;
    #1 check("rd0_no_raw", raw_hazard, 0);
    mem_if.valid = 1'b1; mem_if.data_addr = 20'h00400; mem_if.load_data = 32'h12345678;
    tick();
    mem_if.valid = 1'b0;
    check("rd0_wb_valid", wb_valid, 1);
    check("rd0_wb_rd", wb_rd, 0);
    check("rd0_wb_data", wb_data, 32'h12345678);
    check("rd0_pending0", pending_count, 0);
    check("rd0_no_error", resp_error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
